flux_rd_scheduler: RTL

//  Weighted round-robin read scheduler for the shared multi-flow tagged FIFO (FIFO_SR).

---
 rtl/flux_rd_scheduler.sv | 102 ++++++++++
 1 files changed

// File: rtl/flux_rd_scheduler.sv
// Weighted round-robin read scheduler for the shared multi-flow FIFO.
// Issues one-hot rd pulses, captures the returned word and presents it as a tagged valid/ready stream.
module flux_rd_scheduler #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
  parameter int QW    = 4,
  localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 en,
  input  logic [FLUX*QW-1:0]   quota,
  input  logic [FLUX-1:0]      empty,
  output logic [FLUX-1:0]      rd,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_W-1:0]     out_flux,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]       state;
  logic [TAG_W-1:0] ptr, gsel, g;
  logic [QW-1:0]    burst_cnt, q_ptr, qeff_ptr;
  logic             hit, cont, slot_free;

  assign slot_free = !out_valid || out_ready;
  assign busy      = (state == S_READ) || (state == S_CAPT);

  // burst_cnt==0 only after reset: no burst is open yet, so the search from ptr+1 picks flow 0 first.
  always_comb begin
    q_ptr    = quota[int'(ptr)*QW +: QW];
    qeff_ptr = (q_ptr == '0) ? QW'(1) : q_ptr;
    cont     = (burst_cnt != '0) && !empty[ptr] && (burst_cnt < qeff_ptr);
    hit      = cont;
    g        = ptr;
    if (!cont) begin
      for (int i = 1; i <= FLUX; i++) begin
        if (!hit && !empty[(int'(ptr) + i) % FLUX]) begin
          hit = 1'b1;
          g   = TAG_W'((int'(ptr) + i) % FLUX);
        end
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd        <= '0;
      ptr       <= TAG_W'(FLUX - 1);
      gsel      <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && slot_free && hit) begin
            rd    <= FLUX'(1) << g;
            gsel  <= g;
            state <= S_READ;
            if (cont) begin
              burst_cnt <= burst_cnt + QW'(1);
            end else begin
              ptr       <= g;
              burst_cnt <= QW'(1);
            end
          end
        end
        S_READ: begin
          rd    <= '0;
          state <= S_CAPT;
        end
        S_CAPT:  state <= S_IDLE;
        default: begin
          rd    <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Capture wins over a same-cycle accept; the held word is frozen while stalled.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flux  <= '0;
    end else if (state == S_CAPT) begin
      out_valid <= 1'b1;
      out_data  <= fifo_data;
      out_flux  <= gsel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
